// File: rtl/job_desc_dispatcher_pkg.sv
// Shared definitions for the job descriptor dispatcher: descriptor field
// layout, default magic value and the dispatcher FSM state encoding.
package snap_job_pkg;

   localparam int unsigned MAGIC_LSB = 0;
   localparam int unsigned MAGIC_MSB = 15;
   localparam int unsigned LAST_BIT  = 16;
   localparam int unsigned NEXT_LSB  = 64;
   localparam int unsigned NEXT_MSB  = 127;

   localparam logic [15:0] DESC_MAGIC_DEFAULT = 16'h4A42;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_REQ,
      FETCH_WAIT,
      DISPATCH,
      WAIT_START,
      DRAIN,
      DONE,
      ERROR
   } state_e;

endpackage

// File: rtl/job_desc_dispatcher_check.sv
// Combinational descriptor field extraction: magic check, last flag,
// next pointer and its alignment.
module job_desc_check
   import snap_job_pkg::*;
#(
   parameter int unsigned DESC_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DESC_ALIGN = 6,
   parameter logic [15:0] DESC_MAGIC = DESC_MAGIC_DEFAULT
) (
   input  logic [DESC_WIDTH-1:0] desc,
   output logic                  magic_ok,
   output logic                  last,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  next_aligned
);

   // Reserved and payload bits are deliberately ignored here.
   logic unused_desc_bits;
   assign unused_desc_bits = ^desc;

   assign magic_ok     = (desc[MAGIC_MSB:MAGIC_LSB] == DESC_MAGIC);
   assign last         = desc[LAST_BIT];
   assign next_addr    = desc[NEXT_LSB +: ADDR_WIDTH];
   assign next_aligned = (next_addr[DESC_ALIGN-1:0] == '0);

endmodule

// File: rtl/job_desc_dispatcher.sv
// Job-manager front end: fetches descriptors from host memory, optionally
// follows the chain, and dispatches each one to the first free kernel.
module job_desc_dispatcher
   import snap_job_pkg::*;
#(
   parameter int unsigned KERNEL_NUM = 8,
   parameter int unsigned DESC_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DESC_ALIGN = 6,
   parameter logic [15:0] DESC_MAGIC = DESC_MAGIC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  manager_start,
   input  logic                  run_mode,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic                  new_job,
   input  logic                  job_done,
   input  logic [KERNEL_NUM-1:0] kernel_start,
   output logic                  job_start,
   output logic [DESC_WIDTH-1:0] job_desc,
   output logic                  rd_req_valid,
   input  logic                  rd_req_ready,
   output logic [ADDR_WIDTH-1:0] rd_req_addr,
   input  logic                  rd_rsp_valid,
   output logic                  rd_rsp_ready,
   input  logic [DESC_WIDTH-1:0] rd_rsp_data,
   output logic [31:0]           jobs_dispatched,
   output logic                  run_done,
   output logic                  run_error
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
   logic [DESC_WIDTH-1:0]   job_desc_q, job_desc_d;
   logic [31:0]             cnt_q, cnt_d;
   logic                    mstart_q, mstart_d;

   logic [DESC_WIDTH-1:0]   chk_desc;
   logic                    magic_ok, desc_last, next_aligned;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic                    start_edge;

   // The response is checked before latching; afterwards the held copy is.
   assign chk_desc   = (state_q == FETCH_WAIT) ? rd_rsp_data : job_desc_q;
   assign start_edge = manager_start & ~mstart_q;
   assign mstart_d   = manager_start;

   job_desc_check #(
      .DESC_WIDTH (DESC_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DESC_ALIGN (DESC_ALIGN),
      .DESC_MAGIC (DESC_MAGIC)
   ) u_check (
      .desc         (chk_desc),
      .magic_ok     (magic_ok),
      .last         (desc_last),
      .next_addr    (next_addr),
      .next_aligned (next_aligned)
   );

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      job_desc_d   = job_desc_q;
      cnt_d        = cnt_q;
      job_start    = 1'b0;
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               cur_addr_d = init_addr;
               cnt_d      = '0;
               state_d    = (init_addr[DESC_ALIGN-1:0] == '0) ? FETCH_REQ : ERROR;
            end
         end
         FETCH_REQ: begin
            if (!manager_start) begin
               state_d = IDLE;
            end else begin
               rd_req_valid = 1'b1;
               if (rd_req_ready) state_d = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            // An accepted request is always drained, even after an abort.
            rd_rsp_ready = 1'b1;
            if (rd_rsp_valid) begin
               if (!manager_start) begin
                  state_d = IDLE;
               end else begin
                  job_desc_d = rd_rsp_data;
                  state_d    = magic_ok ? DISPATCH : ERROR;
               end
            end
         end
         DISPATCH: begin
            if (!manager_start) begin
               state_d = IDLE;
            end else if (new_job) begin
               job_start = 1'b1;
               state_d   = WAIT_START;
            end
         end
         WAIT_START: begin
            if (kernel_start != '0) begin
               if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
               if (!manager_start) begin
                  state_d = IDLE;
               end else if (!run_mode || desc_last) begin
                  state_d = DRAIN;
               end else if (!next_aligned) begin
                  state_d = ERROR;
               end else begin
                  cur_addr_d = next_addr;
                  state_d    = FETCH_REQ;
               end
            end else begin
               state_d = manager_start ? DISPATCH : IDLE;
            end
         end
         DRAIN: begin
            if (!manager_start)  state_d = IDLE;
            else if (job_done)   state_d = DONE;
         end
         DONE, ERROR: begin
            if (!manager_start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         job_desc_q <= '0;
         cnt_q      <= '0;
         mstart_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         job_desc_q <= job_desc_d;
         cnt_q      <= cnt_d;
         mstart_q   <= mstart_d;
      end
   end

   assign rd_req_addr     = cur_addr_q;
   assign job_desc        = job_desc_q;
   assign jobs_dispatched = cnt_q;
   assign run_done        = (state_q == DONE);
   assign run_error       = (state_q == ERROR);

endmodule

// File: tb/tb_job_desc_dispatcher.sv
// Directed bench for job_desc_dispatcher: single, chained, back-pressure,
// lost-race, error and abort scenarios with hand-computed expectations.
module tb_job_desc_dispatcher;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         manager_start;
   logic         run_mode;
   logic [63:0]  init_addr;
   logic         new_job;
   logic         job_done;
   logic [7:0]   kernel_start;
   logic         job_start;
   logic [511:0] job_desc;
   logic         rd_req_valid;
   logic         rd_req_ready;
   logic [63:0]  rd_req_addr;
   logic         rd_rsp_valid;
   logic         rd_rsp_ready;
   logic [511:0] rd_rsp_data;
   logic [31:0]  jobs_dispatched;
   logic         run_done;
   logic         run_error;

   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   job_desc_dispatcher #(
      .KERNEL_NUM (8),
      .DESC_WIDTH (512),
      .ADDR_WIDTH (64),
      .DESC_ALIGN (6),
      .DESC_MAGIC (16'h4A42)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .manager_start   (manager_start),
      .run_mode        (run_mode),
      .init_addr       (init_addr),
      .new_job         (new_job),
      .job_done        (job_done),
      .kernel_start    (kernel_start),
      .job_start       (job_start),
      .job_desc        (job_desc),
      .rd_req_valid    (rd_req_valid),
      .rd_req_ready    (rd_req_ready),
      .rd_req_addr     (rd_req_addr),
      .rd_rsp_valid    (rd_rsp_valid),
      .rd_rsp_ready    (rd_rsp_ready),
      .rd_rsp_data     (rd_rsp_data),
      .jobs_dispatched (jobs_dispatched),
      .run_done        (run_done),
      .run_error       (run_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [511:0] mk_desc(input logic [15:0] magic, input logic last,
                                            input logic [63:0] nxt, input logic [31:0] tag);
      logic [511:0] d;
      d          = '0;
      d[15:0]    = magic;
      d[16]      = last;
      d[63:17]   = 47'h5A5A_1234_0F0F;
      d[127:64]  = nxt;
      d[511:480] = tag;
      d[300:269] = ~tag;
      return d;
   endfunction

   task automatic start_run();
      manager_start = 1'b0;
      tick();
      manager_start = 1'b1;
   endtask

   task automatic wait_req(input string tag, output logic found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rd_req_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, "_req_seen"}, 64'(found), 64'd1);
   endtask

   task automatic serve_read(input string tag, input logic [63:0] exp_addr, input logic [511:0] data,
                             input int req_delay, input int rsp_delay);
      logic found;
      wait_req(tag, found);
      if (found) begin
         chk({tag, "_addr"}, rd_req_addr, exp_addr);
         for (int i = 0; i < req_delay; i++) begin
            tick();
            chk({tag, "_bp_valid"}, 64'(rd_req_valid), 64'd1);
            chk({tag, "_bp_addr"}, rd_req_addr, exp_addr);
         end
         rd_req_ready = 1'b1;
         tick();
         rd_req_ready = 1'b0;
         chk({tag, "_wait_valid"}, 64'(rd_req_valid), 64'd0);
         chk({tag, "_wait_rready"}, 64'(rd_rsp_ready), 64'd1);
         for (int i = 0; i < rsp_delay; i++) begin
            tick();
            chk({tag, "_rsp_wait_js"}, 64'(job_start), 64'd0);
            chk({tag, "_rsp_wait_rready"}, 64'(rd_rsp_ready), 64'd1);
         end
         rd_rsp_valid = 1'b1;
         rd_rsp_data  = data;
         tick();
         rd_rsp_valid = 1'b0;
         rd_rsp_data  = '0;
      end
   endtask

   task automatic kick(input string tag, input logic [7:0] ks, input logic [511:0] exp_desc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (job_start === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, "_js_seen"}, 64'(found), 64'd1);
      chk({tag, "_desc_lo"}, job_desc[63:0], exp_desc[63:0]);
      chk({tag, "_desc_next"}, job_desc[127:64], exp_desc[127:64]);
      chk({tag, "_desc_pay"}, job_desc[511:448], exp_desc[511:448]);
      tick();
      kernel_start = ks;
      #1;
      chk({tag, "_js_one_cycle"}, 64'(job_start), 64'd0);
      tick();
      kernel_start = '0;
   endtask

   logic [511:0] d1, d2, d3;
   logic         seen;

   initial begin
      rst_n         = 1'b0;
      manager_start = 1'b1;
      run_mode      = 1'b0;
      init_addr     = 64'h1000;
      new_job       = 1'b1;
      job_done      = 1'b0;
      kernel_start  = '0;
      rd_req_ready  = 1'b0;
      rd_rsp_valid  = 1'b0;
      rd_rsp_data   = '0;
      tick();
      tick();
      chk("rst_job_start", 64'(job_start), 64'd0);
      chk("rst_req_valid", 64'(rd_req_valid), 64'd0);
      chk("rst_rsp_ready", 64'(rd_rsp_ready), 64'd0);
      chk("rst_count", 64'(jobs_dispatched), 64'd0);
      chk("rst_done", 64'(run_done), 64'd0);
      chk("rst_error", 64'(run_error), 64'd0);
      chk("rst_desc", job_desc[63:0], 64'd0);
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      chk("start_high_at_reset_no_req", 64'(rd_req_valid), 64'd0);

      // Single descriptor run
      d1 = mk_desc(16'h4A42, 1'b0, 64'h9000, 32'hA1A1_0001);
      run_mode = 1'b0;
      start_run();
      serve_read("single", 64'h1000, d1, 0, 0);
      kick("single", 8'h80, d1);
      chk("single_count", 64'(jobs_dispatched), 64'd1);
      chk("single_not_done_yet", 64'(run_done), 64'd0);
      chk("single_no_req_drain", 64'(rd_req_valid), 64'd0);
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      chk("single_done", 64'(run_done), 64'd1);
      manager_start = 1'b0;
      tick();
      chk("single_done_clear", 64'(run_done), 64'd0);

      // Chain of three, with back-pressure and a lost race
      d1 = mk_desc(16'h4A42, 1'b0, 64'h2040, 32'hC0C0_0001);
      d2 = mk_desc(16'h4A42, 1'b0, 64'h3000, 32'hC0C0_0002);
      d3 = mk_desc(16'h4A42, 1'b1, 64'h0,    32'hC0C0_0003);
      run_mode = 1'b1;
      start_run();
      serve_read("chain1", 64'h1000, d1, 0, 0);
      kick("chain1_lost", 8'h00, d1);
      chk("lost_race_count", 64'(jobs_dispatched), 64'd0);
      kick("chain1", 8'h01, d1);
      chk("chain1_count", 64'(jobs_dispatched), 64'd1);
      serve_read("chain2_bp", 64'h2040, d2, 5, 7);
      kick("chain2", 8'h04, d2);
      chk("chain2_count", 64'(jobs_dispatched), 64'd2);
      serve_read("chain3", 64'h3000, d3, 1, 1);
      kick("chain3", 8'h10, d3);
      chk("chain3_count", 64'(jobs_dispatched), 64'd3);
      chk("chain_no_fourth_req", 64'(rd_req_valid), 64'd0);
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      chk("chain_done", 64'(run_done), 64'd1);
      manager_start = 1'b0;
      tick();

      // Bad magic
      d1 = mk_desc(16'h0000, 1'b0, 64'h0, 32'hBAD0_0001);
      run_mode = 1'b0;
      start_run();
      serve_read("badmagic", 64'h1000, d1, 0, 0);
      chk("badmagic_error", 64'(run_error), 64'd1);
      chk("badmagic_no_js", 64'(job_start), 64'd0);
      tick();
      chk("badmagic_no_js2", 64'(job_start), 64'd0);
      chk("badmagic_count", 64'(jobs_dispatched), 64'd0);
      manager_start = 1'b0;
      tick();
      chk("badmagic_error_clear", 64'(run_error), 64'd0);

      // Misaligned next pointer after one dispatch
      d1 = mk_desc(16'h4A42, 1'b0, 64'h2044, 32'hBAD0_0002);
      run_mode = 1'b1;
      start_run();
      serve_read("badnext", 64'h1000, d1, 0, 0);
      kick("badnext", 8'h02, d1);
      chk("badnext_error", 64'(run_error), 64'd1);
      chk("badnext_count", 64'(jobs_dispatched), 64'd1);
      chk("badnext_no_req", 64'(rd_req_valid), 64'd0);
      manager_start = 1'b0;
      tick();
      chk("badnext_error_clear", 64'(run_error), 64'd0);

      // Misaligned init address goes straight to error
      init_addr = 64'h1010;
      start_run();
      tick();
      chk("badinit_error", 64'(run_error), 64'd1);
      chk("badinit_no_req", 64'(rd_req_valid), 64'd0);
      manager_start = 1'b0;
      tick();
      init_addr = 64'h1000;

      // Abort before request handshake drops valid
      run_mode = 1'b0;
      start_run();
      wait_req("abort_req", seen);
      manager_start = 1'b0;
      #1;
      chk("abort_req_valid_drop", 64'(rd_req_valid), 64'd0);
      tick();
      chk("abort_req_idle", 64'(rd_req_valid), 64'd0);

      // Abort during FETCH_WAIT: response still consumed, then idle
      init_addr = 64'h4000;
      start_run();
      wait_req("abort_wait", seen);
      rd_req_ready = 1'b1;
      tick();
      rd_req_ready  = 1'b0;
      manager_start = 1'b0;
      tick();
      chk("abort_wait_rready", 64'(rd_rsp_ready), 64'd1);
      chk("abort_wait_no_req", 64'(rd_req_valid), 64'd0);
      tick();
      chk("abort_wait_rready2", 64'(rd_rsp_ready), 64'd1);
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = mk_desc(16'h4A42, 1'b0, 64'h0, 32'hAB0A_0001);
      tick();
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = '0;
      chk("abort_idle_rready", 64'(rd_rsp_ready), 64'd0);
      chk("abort_idle_valid", 64'(rd_req_valid), 64'd0);
      tick();
      tick();
      chk("abort_no_new_req", 64'(rd_req_valid), 64'd0);
      chk("abort_no_js", 64'(job_start), 64'd0);

      // Fresh run after abort
      d1 = mk_desc(16'h4A42, 1'b1, 64'h0, 32'hF4E5_0001);
      start_run();
      tick();
      chk("fresh_count_zero", 64'(jobs_dispatched), 64'd0);
      serve_read("fresh", 64'h4000, d1, 0, 2);
      kick("fresh", 8'h08, d1);
      chk("fresh_count", 64'(jobs_dispatched), 64'd1);
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      chk("fresh_done", 64'(run_done), 64'd1);
      manager_start = 1'b0;
      tick();
      chk("fresh_done_clear", 64'(run_done), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/job_desc_dispatcher.md
Name: job_desc_dispatcher

Overview:
- Job-manager front end. Upstream of the global control slave, which supplies manager_start, run_mode, init_addr, new_job, job_done and kernel_start, and consumes job_start.
- Fetches fixed-size job descriptors from host memory over a simple read request/response port, starting at init_addr.
- In chained mode (run_mode=1) it follows next pointers. For each descriptor it presents the descriptor to all kernels and pulses job_start when a kernel is free.
- The kernel whose kernel_start bit fires captures job_desc.

Parameters:
- KERNEL_NUM, 8, number of kernels; width of kernel_start.
- DESC_WIDTH, 512, descriptor width in bits. Minimum 128. One read beat.
- ADDR_WIDTH, 64, host address width.
- DESC_ALIGN, 6, log2 of descriptor byte alignment. Address bits [DESC_ALIGN-1:0] must be 0.
- DESC_MAGIC, 16'h4A42, required value of descriptor bits [15:0].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- manager_start  in  1  level enable; a 0->1 edge starts a run
- run_mode  in  1  0 = single descriptor, 1 = chained list
- init_addr  in  ADDR_WIDTH  first descriptor address
- new_job  in  1  at least one kernel idle
- job_done  in  1  all kernels idle
- kernel_start  in  KERNEL_NUM  one-hot, one cycle after the job_start pulse
- job_start  out  1  one-cycle dispatch request
- job_desc  out  DESC_WIDTH  current descriptor; stable from the job_start pulse until kernel_start is seen
- rd_req_valid  out  1  descriptor read request valid
- rd_req_ready  in  1  read request accepted
- rd_req_addr  out  ADDR_WIDTH  descriptor address
- rd_rsp_valid  in  1  read data valid
- rd_rsp_ready  out  1  read data accepted
- rd_rsp_data  in  DESC_WIDTH  descriptor data
- jobs_dispatched  out  32  jobs dispatched this run
- run_done  out  1  run complete, held until manager_start=0
- run_error  out  1  bad descriptor or bad alignment, held until manager_start=0

Behaviour:
- Reset values: all outputs 0. FSM resets to IDLE. The manager_start edge register resets to 1, so a start already high at reset release is not treated as an edge.
- Descriptor fields: [15:0] magic, [16] last, [63:17] reserved (ignored), [127:64] next_addr. Bits above 127 are payload and are passed through untouched.
- IDLE: on a manager_start rising edge, latch cur_addr=init_addr and clear jobs_dispatched.
  - If init_addr is misaligned -> ERROR.
  - Otherwise -> FETCH_REQ.
- FETCH_REQ: rd_req_valid=1, rd_req_addr=cur_addr. Valid is held and the address is stable until rd_req_ready. On handshake -> FETCH_WAIT.
- FETCH_WAIT: rd_rsp_ready=1. On rd_rsp_valid, latch job_desc=rd_rsp_data.
  - If the magic field is not DESC_MAGIC -> ERROR.
  - Otherwise -> DISPATCH.
- DISPATCH: when new_job=1, drive job_start=1 for exactly one cycle -> WAIT_START.
- WAIT_START (exactly one cycle):
  - If kernel_start is nonzero: jobs_dispatched+1, saturating at 32'hFFFFFFFF.
    - If run_mode=0 or last=1 -> DRAIN.
    - Else if next_addr is misaligned -> ERROR.
    - Else cur_addr=next_addr -> FETCH_REQ.
  - If kernel_start=0 (lost race): -> DISPATCH and retry. Not counted.
- run_mode is sampled in WAIT_START, never latched.
- DRAIN: when job_done=1 -> DONE.
- DONE: run_done=1. ERROR: run_error=1. Both states return to IDLE when manager_start=0, which clears the flag.
- Abort: manager_start falling in any busy state:
  - In FETCH_REQ or FETCH_WAIT, complete any accepted request first (consume the response) and never issue a new request. Then -> IDLE.
  - In FETCH_REQ before handshake: drop valid -> IDLE.
  - DISPATCH / DRAIN -> IDLE.
  - WAIT_START finishes its cycle, then -> IDLE.
- A manager_start edge while not in IDLE is ignored.
- Handshake response is never earlier than the next cycle; rd_req_valid and rd_rsp_ready never both high in one state.
- Only one outstanding read at a time.
- Asynchronous reset mid-run returns to IDLE immediately; any in-flight response after reset is not the block's concern.

Decomposition:
- Package snap_job_pkg:
  - descriptor field offsets (MAGIC_LSB/MSB, LAST_BIT, NEXT_LSB/MSB)
  - DESC_MAGIC default
  - FSM state enum: IDLE, FETCH_REQ, FETCH_WAIT, DISPATCH, WAIT_START, DRAIN, DONE, ERROR
- One sub-module: job_desc_check. Combinational field extract giving magic_ok, last, next_addr and next_aligned from a descriptor word. Reused by the host-side descriptor writer bench model.

Test Plan:
- Single mode: run_mode=0, init_addr=0x1000, valid desc, new_job=1 -> one read at 0x1000; job_start pulse; kernel_start=8'h80 next cycle; jobs_dispatched=1; run_done after job_done=1.
- Chain of 3: addresses 0x1000 -> 0x2040 -> 0x3000, last set on 3rd -> reads in that order; 3 job_start pulses; jobs_dispatched=3; run_done=1.
- Back-pressure: rd_req_ready low 5 cycles, rd_rsp_valid delayed 7 cycles -> rd_req_addr stable; no job_start before the response.
- Lost race: kernel_start=0 after the first job_start -> second job_start pulse later; count increments only once.
- Errors:
  - magic=16'h0000 -> run_error=1, no job_start.
  - next_addr=0x2044 -> run_error=1 after first dispatch, count=1.
  - manager_start=0 -> run_error clears.
- Abort: drop manager_start during FETCH_WAIT -> response consumed, no further request, IDLE. A new edge starts a fresh run with count=0.
